// File: rtl/debounce_filter_if.sv
// Pin bundle between a noisy board-level input and the debounce filter.
// The master drives the raw input; the slave returns the clean level and edge pulses.
interface debounce_filter_if;
  logic io_input;
  logic io_output;
  logic io_rise;
  logic io_fall;

  modport master (output io_input, input io_output, io_rise, io_fall);
  modport slave  (input io_input, output io_output, io_rise, io_fall);
endinterface

// File: rtl/debounce_filter.sv
// Synchronises a raw asynchronous input and only lets a new level through once it has
// persisted for STABLE_CYCLES consecutive clocks; emits one-cycle rise/fall pulses.
module debounce_filter #(
  parameter int unsigned STABLE_CYCLES = 5000,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic        RESET_VALUE   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  debounce_filter_if.slave  io
);

  localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], io.io_input};
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    // One cycle of agreement restarts the count; the flip also restarts it.
    if (sync == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      out_d  = sync;
      cnt_d  = '0;
      rise_d = sync;
      fall_d = ~sync;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the synchronizer flops are reset too, so no stale pre-reset level can leak into the count.
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
      cnt_q  <= '0;
      out_q  <= RESET_VALUE;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign io.io_output = out_q;
  assign io.io_rise   = rise_q;
  assign io.io_fall   = fall_q;

endmodule

// File: tb/tb_debounce_filter.sv
// Bench for debounce_filter: a short-filter instance for directed and random traffic,
// plus a default-parameter instance for the long-latency case.
module tb_debounce_filter;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  debounce_filter_if if_a ();
  debounce_filter_if if_b ();

  debounce_filter #(.STABLE_CYCLES(4), .SYNC_STAGES(2), .RESET_VALUE(1'b0)) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .io  (if_a)
  );

  debounce_filter u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .io  (if_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: sync is the input seen SYNC_STAGES edges ago; the output flips once
  // STABLE_CYCLES edges have elapsed since sync last agreed with it (or since the last flip/reset).
  int          stab   [2] = '{4, 5000};
  int          stages [2] = '{2, 2};
  logic [15:0] dly    [2];
  logic        m_out  [2];
  logic        m_rise [2];
  logic        m_fall [2];
  longint      last_agree [2];
  bit          valid  [2] = '{1'b0, 1'b0};
  longint      cyc = 0;
  logic        m_r, m_in, m_s;

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      m_r  = (i == 0) ? rst_a : rst_b;
      m_in = (i == 0) ? if_a.io_input : if_b.io_input;
      if (m_r) begin
        dly[i]        = '0;
        m_out[i]      = 1'b0;
        m_rise[i]     = 1'b0;
        m_fall[i]     = 1'b0;
        last_agree[i] = cyc;
        valid[i]      = 1'b1;
      end else begin
        m_s       = dly[i][stages[i]-1];
        dly[i]    = {dly[i][14:0], m_in};
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (m_s == m_out[i]) begin
          last_agree[i] = cyc;
        end else if (cyc - last_agree[i] >= longint'(stab[i])) begin
          m_out[i]      = m_s;
          m_rise[i]     = m_s;
          m_fall[i]     = ~m_s;
          last_agree[i] = cyc;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (valid[0])
      check("model_a", {29'd0, if_a.io_output, if_a.io_rise, if_a.io_fall},
            {29'd0, m_out[0], m_rise[0], m_fall[0]});
    if (valid[1])
      check("model_b", {29'd0, if_b.io_output, if_b.io_rise, if_b.io_fall},
            {29'd0, m_out[1], m_rise[1], m_fall[1]});
  end

  // Drive val at the next edge (E0) and hold for 'hold' edges; report the first k (edge E0+k)
  // at which the output equals val (-1 if never) and the pulse counts in that window.
  task automatic drive_hold(input int inst, input logic val, input int hold,
                            output int first_k, output int n_rise, output int n_fall);
    logic o, r, f;
    first_k = -1;
    n_rise  = 0;
    n_fall  = 0;
    if (inst == 0) if_a.io_input = val;
    else           if_b.io_input = val;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      o = (inst == 0) ? if_a.io_output : if_b.io_output;
      r = (inst == 0) ? if_a.io_rise   : if_b.io_rise;
      f = (inst == 0) ? if_a.io_fall   : if_b.io_fall;
      if (first_k < 0 && o == val) first_k = k;
      n_rise += int'(r);
      n_fall += int'(f);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fk, nr, nf, tot_r, tot_f;
    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.io_input = 1'b1;
    if_b.io_input = 1'b0;

    // 1: reset held with input high, then release.
    repeat (3) begin
      @(negedge clk);
      check("s1_reset_out_pulses", {29'd0, if_a.io_output, if_a.io_rise, if_a.io_fall}, 32'd0);
    end
    rst_a = 1'b0;
    drive_hold(0, 1'b1, 10, fk, nr, nf);
    check("s1_latency", fk, 5);
    check("s1_rise_count", nr, 1);
    check("s1_model_pin", {31'd0, m_out[0]}, 32'd1);

    // 2: clean 0->1 step.
    drive_hold(0, 1'b0, 10, fk, nr, nf);
    check("s2_fall_first", nf, 1);
    drive_hold(0, 1'b1, 10, fk, nr, nf);
    check("s2_latency", fk, 5);
    check("s2_rise_count", nr, 1);

    // 3: 3-cycle glitch must be swallowed.
    drive_hold(0, 1'b0, 10, fk, nr, nf);
    drive_hold(0, 1'b1, 3, fk, nr, nf);
    tot_r = nr;
    check("s3_glitch_out", fk, -1);
    drive_hold(0, 1'b0, 20, fk, nr, nf);
    check("s3_rise_count", tot_r + nr, 0);

    // 4: bouncing fall restarts the count.
    drive_hold(0, 1'b1, 10, fk, nr, nf);
    drive_hold(0, 1'b0, 3, fk, nr, nf);
    tot_f = nf;
    drive_hold(0, 1'b1, 1, fk, nr, nf);
    tot_f += nf;
    drive_hold(0, 1'b0, 15, fk, nr, nf);
    check("s4_latency", fk, 5);
    check("s4_fall_count", tot_f + nf, 1);

    // 5: reset mid-count aborts the count.
    drive_hold(0, 1'b1, 4, fk, nr, nf);
    check("s5_no_flip_yet", fk, -1);
    rst_a = 1'b1;
    @(negedge clk);
    check("s5_reset_out", {31'd0, if_a.io_output}, 32'd0);
    rst_a = 1'b0;
    drive_hold(0, 1'b1, 10, fk, nr, nf);
    check("s5_latency", fk, 5);

    // Random segments with occasional resets, checked by the model every cycle.
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
      end
      drive_hold(0, 1'($urandom_range(0, 1)), $urandom_range(1, 8), fk, nr, nf);
    end

    // 6: default parameters, shortened hold times.
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    drive_hold(1, 1'b1, 6000, fk, nr, nf);
    check("s6_rise1_latency", fk, 5001);
    tot_r = nr; tot_f = nf;
    drive_hold(1, 1'b0, 6000, fk, nr, nf);
    check("s6_fall_latency", fk, 5001);
    tot_r += nr; tot_f += nf;
    drive_hold(1, 1'b1, 6000, fk, nr, nf);
    check("s6_rise2_latency", fk, 5001);
    tot_r += nr; tot_f += nf;
    check("s6_rise_count", tot_r, 2);
    check("s6_fall_count", tot_f, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
